pipe_hazard_ctrl: RTL

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

---
 rtl/pipe_hazard_ctrl_pkg.sv | 29 ++
 rtl/pipe_hazard_ctrl_fwd_sel.sv | 24 ++
 rtl/pipe_hazard_ctrl.sv | 123 ++++++++++++
 3 files changed

// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared pipeline definitions: hazard FSM states, operand-select codes and
// the register-number helpers used by the hazard/forwarding logic.
package pipe_hazard_ctrl_pkg;

    localparam int REG_W = 4;
    localparam int CNT_W = 16;

    localparam logic [REG_W-1:0] PC_REG = 4'd15;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b01;
    localparam logic [1:0] FWD_WB  = 2'b10;

    typedef enum logic [1:0] {
        IDLE       = 2'b00,
        LOAD_STALL = 2'b01,
        BR_FLUSH   = 2'b10
    } hz_state_t;

    // A producer feeds a consumer only for a real read of a real write, and
    // never for the PC, whose value is not carried down the pipeline.
    function automatic logic reg_match(input logic [REG_W-1:0] src,
                                       input logic             srcUse,
                                       input logic [REG_W-1:0] dst,
                                       input logic             dstWe);
        return srcUse && dstWe && (src == dst) && (src != PC_REG);
    endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_fwd_sel.sv
// Per-operand bypass select: the youngest matching producer wins, so the
// memory stage takes precedence over writeback.
module hazard_fwd_sel
    import pipe_hazard_ctrl_pkg::*;
(
    input  logic [REG_W-1:0] srcReg,
    input  logic             srcUse,
    input  logic [REG_W-1:0] memRegD,
    input  logic             memWe,
    input  logic [REG_W-1:0] wbRegD,
    input  logic             wbWe,
    output logic [1:0]       sel
);

    always_comb begin
        sel = FWD_RF;
        if (reg_match(srcReg, srcUse, memRegD, memWe)) begin
            sel = FWD_MEM;
        end else if (reg_match(srcReg, srcUse, wbRegD, wbWe)) begin
            sel = FWD_WB;
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: operand forwarding, load-use stalls, taken-branch
// flushes, and saturating event counters for stalls and flushes.
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic [REG_W-1:0] decoRegA,
    input  logic [REG_W-1:0] decoRegB,
    input  logic             decoUseA,
    input  logic             decoUseB,
    input  logic [REG_W-1:0] exeRegD,
    input  logic             exeWe,
    input  logic             exeIsLoad,
    input  logic [REG_W-1:0] memRegD,
    input  logic             memWe,
    input  logic [REG_W-1:0] wbRegD,
    input  logic             wbWe,
    input  logic             exeBranchTaken,
    output logic             stallFetch,
    output logic             stallDeco,
    output logic             flushFetchDeco,
    output logic             flushDecoExe,
    output logic [1:0]       fwdA,
    output logic [1:0]       fwdB,
    output logic [CNT_W-1:0] stallCount,
    output logic [CNT_W-1:0] flushCount
);

    hz_state_t  state;
    logic [1:0] selA;
    logic [1:0] selB;
    logic       loadUse;
    logic       flushing;
    logic       stallReq;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
    endfunction

    hazard_fwd_sel u_fwd_a (
        .srcReg  (decoRegA),
        .srcUse  (decoUseA),
        .memRegD (memRegD),
        .memWe   (memWe),
        .wbRegD  (wbRegD),
        .wbWe    (wbWe),
        .sel     (selA)
    );

    hazard_fwd_sel u_fwd_b (
        .srcReg  (decoRegB),
        .srcUse  (decoUseB),
        .memRegD (memRegD),
        .memWe   (memWe),
        .wbRegD  (wbRegD),
        .wbWe    (wbWe),
        .sel     (selB)
    );

    assign loadUse = exeIsLoad &&
                     (reg_match(decoRegA, decoUseA, exeRegD, exeWe) ||
                      reg_match(decoRegB, decoUseB, exeRegD, exeWe));

    // A branch resolving now, or one resolved last cycle, squashes both
    // younger pipe registers; stalling behind a squashed instruction is moot.
    assign flushing = exeBranchTaken || (state == BR_FLUSH);
    assign stallReq = loadUse && !flushing;

    always_comb begin
        stallFetch     = 1'b0;
        stallDeco      = 1'b0;
        flushFetchDeco = 1'b0;
        flushDecoExe   = 1'b0;
        fwdA           = FWD_RF;
        fwdB           = FWD_RF;
        if (rst) begin
            stallFetch     = stallReq;
            stallDeco      = stallReq;
            flushFetchDeco = flushing;
            flushDecoExe   = flushing || stallReq;
            fwdA           = selA;
            fwdB           = selB;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (exeBranchTaken) begin
                        state <= BR_FLUSH;
                    end else if (loadUse) begin
                        state <= LOAD_STALL;
                    end
                end
                LOAD_STALL, BR_FLUSH: begin
                    state <= exeBranchTaken ? BR_FLUSH : IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            stallCount <= '0;
            flushCount <= '0;
        end else begin
            if (stallDeco) begin
                stallCount <= sat_inc(stallCount);
            end
            if (exeBranchTaken) begin
                flushCount <= sat_inc(flushCount);
            end
        end
    end

endmodule
